imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side initiator for the instruction memory's byte-enabled write port (adra/dina/wea).
- Accepts a byte stream over valid/ready (from the UART/boot path) and packs bytes little-endian into 32-bit words.
- Issues one registered, byte-masked write per completed or final partial word, at sequential word addresses from a programmable base.
- Sits between the boot/host interface and imem; the core's fetch uses the read port independently.

Parameters:
- ADDR_WIDTH, `INST_MEM_ADDR_WIDTH, word-address width of the instruction memory
- LEN_WIDTH, 16, width of the byte-count input
- XLEN, 32, data word width; only 32 is supported

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address; captured on accepted start
- byte_len  in  LEN_WIDTH  number of bytes to load; captured on accepted start
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts the byte this cycle
- adra  out  ADDR_WIDTH  imem write word address (registered)
- dina  out  XLEN  imem write data (registered)
- wea  out  4  imem byte write enables (registered); nonzero for exactly one cycle per write
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at load completion
- wrap_err  out  1  sticky flag: word address wrapped past the top of memory during this load

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; adra=0, dina=0, wea=0, in_ready=0, busy=0, done=0, wrap_err=0; byte/lane counters and accumulator cleared.
- Reset mid-load: any partial word is dropped and no write is issued; wea must go 0 immediately.
- Handshake: a byte transfers on a posedge when in_valid && in_ready. in_ready=1 only in RECV. in_ready is independent of in_valid. Throughput is 1 byte/cycle with no bubbles.
- States: IDLE, RECV, FLUSH.
- IDLE: on start with byte_len>0, capture base_addr into waddr and byte_len into remaining; clear lane=0, acc=0, mask=0, wrap_err=0; go to RECV. On start with byte_len==0, clear wrap_err, go to FLUSH, issue no write.
- start outside IDLE is ignored.
- RECV, on each transfer:
  - acc[8*lane+:8] <= in_data; mask[lane] <= 1; lane <= lane+1 (mod 4); remaining <= remaining-1.
  - Write trigger: lane==3 or remaining==1.
  - On trigger, next cycle: adra=waddr, dina=acc with the current byte merged, wea=mask with the current bit set. Then clear acc and mask, and increment waddr modulo 2^ADDR_WIDTH.
  - If waddr was all-ones when incremented and bytes remain, set wrap_err.
  - A transfer with remaining==1 moves the FSM to FLUSH.
- Unwritten byte lanes in dina are 0. wea masks them, so the memory keeps its old contents there.
- FLUSH: lasts one cycle. done=1 in this cycle, which is the same cycle the final wea is presented; then go to IDLE.
- wea is 0 in every cycle that does not follow a trigger. Consecutive full words may produce writes 4 cycles apart, never back-to-back.
- adra and dina hold their last values when wea=0.
- Final-word masks: a final word with 1, 2, or 3 bytes gives wea=4'b0001, 4'b0011, or 4'b0111 respectively.
- wrap_err stays set until the next accepted start or reset.
- remaining never underflows; no transfers are accepted once it reaches 0.

Test Plan:
- Reset with in_valid=1 → in_ready=0, wea=0, busy=0, done=0 while reset=0 and after release in IDLE.
- start, base_addr=0x010, byte_len=8, bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 with in_valid held high → adra=0x010, dina=0x00000013, wea=4'hF, then adra=0x011, dina=0x00100093, wea=4'hF; done pulses with the second write; readback of imem matches.
- byte_len=6, bytes 0xAA..0xFF at base 0x020 (memory preloaded with 0x11111111) → second write wea=4'b0011, dina=0x0000FFEE; memory word 0x021 reads 0x1111FFEE.
- Random in_valid gaps (50%) for byte_len=12 → exactly 3 writes, correct data, no byte lost or duplicated, in_ready low after the last byte.
- base_addr=all-ones, byte_len=8 → writes at the top address then address 0; wrap_err=1 after the second write; cleared on the next start.
- byte_len=0 → no wea, done one cycle after start. Separately, assert reset after 2 bytes of a 4-byte load → no write ever issued, busy=0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream to imem write-port loader: packs bytes little-endian into 32-bit words and
// issues one registered, byte-masked write per full or final partial word.

`ifndef INST_MEM_ADDR_WIDTH
`define INST_MEM_ADDR_WIDTH 10
`endif

module imem_loader #(
  parameter int unsigned ADDR_WIDTH = `INST_MEM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned XLEN       = 32  // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  byte_len,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] adra,
  output logic [XLEN-1:0]       dina,
  output logic [3:0]            wea,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap_err
);

  typedef enum logic [1:0] {StIdle, StRecv, StFlush} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [1:0]            lane_q, lane_d;
  logic [XLEN-1:0]       acc_q, acc_d, acc_new;
  logic [3:0]            mask_q, mask_d, mask_new;
  logic [ADDR_WIDTH-1:0] adra_q, adra_d;
  logic [XLEN-1:0]       dina_q, dina_d;
  logic [3:0]            wea_q, wea_d;
  logic                  wrap_err_q, wrap_err_d;
  logic                  xfer, last_byte;

  assign in_ready  = (state_q == StRecv) && (remaining_q != '0);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFlush);
  assign adra      = adra_q;
  assign dina      = dina_q;
  assign wea       = wea_q;
  assign wrap_err  = wrap_err_q;
  assign xfer      = in_valid && in_ready;
  assign last_byte = (remaining_q == LEN_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    adra_d      = adra_q;
    dina_d      = dina_q;
    wea_d       = 4'b0000;
    wrap_err_d  = wrap_err_q;
    acc_new     = acc_q;
    mask_new    = mask_q | (4'b0001 << lane_q);
    acc_new[{lane_q, 3'b000} +: 8] = in_data;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          wrap_err_d = 1'b0;
          if (byte_len != '0) begin
            waddr_d     = base_addr;
            remaining_d = byte_len;
            lane_d      = 2'd0;
            acc_d       = '0;
            mask_d      = 4'b0000;
            state_d     = StRecv;
          end else begin
            state_d = StFlush;
          end
        end
      end
      StRecv: begin
        if (xfer) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          lane_d      = lane_q + 2'd1;
          if (lane_q == 2'd3 || last_byte) begin
            adra_d  = waddr_q;
            dina_d  = acc_new;
            wea_d   = mask_new;
            acc_d   = '0;
            mask_d  = 4'b0000;
            waddr_d = waddr_q + ADDR_WIDTH'(1);
            // Wrapping only matters if more bytes will land at the wrapped address.
            if ((&waddr_q) && !last_byte) wrap_err_d = 1'b1;
          end else begin
            acc_d  = acc_new;
            mask_d = mask_new;
          end
          if (last_byte) state_d = StFlush;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      remaining_q <= '0;
      lane_q      <= 2'd0;
      acc_q       <= '0;
      mask_q      <= 4'b0000;
      adra_q      <= '0;
      dina_q      <= '0;
      wea_q       <= 4'b0000;
      wrap_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      adra_q      <= adra_d;
      dina_q      <= dina_d;
      wea_q       <= wea_d;
      wrap_err_q  <= wrap_err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads, write scoreboard, memory model,
// plus reset corner sequences.

module tb_imem_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   byte_len;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] adra;
  logic [31:0]   dina;
  logic [3:0]    wea;
  logic          busy;
  logic          done;
  logic          wrap_err;

  imem_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .byte_len  (byte_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .adra      (adra),
    .dina      (dina),
    .wea       (wea),
    .busy      (busy),
    .done      (done),
    .wrap_err  (wrap_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    m;
    logic          last;
  } wr_t;

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    bit            gaps;
    logic [95:0]   pat;        // byte i = pat[8*i +: 8]
    int            exp_writes;
    logic [3:0]    exp_last_m;
    bit            exp_wrap;
    logic [AW-1:0] chk_addr;
    logic [31:0]   pre;
    logic [31:0]   chk_val;
  } load_t;

  wr_t         exp_q[$];
  logic [31:0] mem [1024];
  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [3:0]  last_wea = 4'b0000;
  logic        prev_wr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: pops the scoreboard and updates the memory model.
  always @(negedge clk) begin
    if (reset) begin
      if (done) done_cnt++;
      if (wea != 4'b0000) begin
        wr_t w;
        wr_cnt++;
        last_wea = wea;
        check("no_back_to_back", {63'd0, prev_wr}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {54'd0, adra}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("adra", {54'd0, adra}, {54'd0, w.a});
          check("dina", {32'd0, dina}, {32'd0, w.d});
          check("wea",  {60'd0, wea},  {60'd0, w.m});
          check("done_with_last", {63'd0, done}, {63'd0, w.last});
        end
        for (int l = 0; l < 4; l++)
          if (wea[l]) mem[adra][8*l +: 8] = dina[8*l +: 8];
      end
      prev_wr = (wea != 4'b0000);
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic run_load(input load_t t);
    int   wr0 = wr_cnt;
    int   dn0 = done_cnt;
    int   idx = 0;
    int   cyc = 0;
    logic acc;
    wr_t  w;
    mem[t.chk_addr] = t.pre;
    last_wea = 4'b0000;
    for (int wi = 0; wi * 4 < t.len; wi++) begin
      w.a = t.base + AW'(wi);
      w.d = '0;
      w.m = 4'b0000;
      for (int l = 0; l < 4; l++) begin
        if (wi * 4 + l < t.len) begin
          w.d[8*l +: 8] = t.pat[8*(wi*4+l) +: 8];
          w.m[l] = 1'b1;
        end
      end
      w.last = ((wi + 1) * 4 >= t.len);
      exp_q.push_back(w);
    end
    base_addr = t.base;
    byte_len  = 16'(t.len);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_clears_wrap", {63'd0, wrap_err}, 64'd0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    if (t.len == 0) check("zero_len_done", {63'd0, done}, 64'd1);
    while (idx < t.len && cyc < 1000) begin
      in_valid = t.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = t.pat[8*idx +: 8];
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bytes_accepted", 64'(idx), 64'(t.len));
    cyc = 0;
    while (busy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("idle_after_load", {63'd0, busy}, 64'd0);
    check("in_ready_low_after", {63'd0, in_ready}, 64'd0);
    check("write_count", 64'(wr_cnt - wr0), 64'(t.exp_writes));
    check("done_pulses", 64'(done_cnt - dn0), 64'd1);
    check("final_mask", {60'd0, last_wea}, {60'd0, t.exp_last_m});
    check("wrap_err", {63'd0, wrap_err}, {63'd0, t.exp_wrap});
    check("mem_readback", {32'd0, mem[t.chk_addr]}, {32'd0, t.chk_val});
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  load_t tbl[7];

  initial begin
    int wr0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    tbl[0] = '{10'h010, 8, 1'b0, 96'h0000_0000_0010_0093_0000_0013, 2, 4'hF, 1'b0,
               10'h011, 32'h0, 32'h0010_0093};
    tbl[1] = '{10'h020, 6, 1'b0, 96'h0000_0000_0000_FFEE_DDCC_BBAA, 2, 4'b0011, 1'b0,
               10'h021, 32'h1111_1111, 32'h1111_FFEE};
    tbl[2] = '{10'h100, 12, 1'b1, 96'h0C0B_0A09_0807_0605_0403_0201, 3, 4'hF, 1'b0,
               10'h102, 32'h0, 32'h0C0B_0A09};
    tbl[3] = '{10'h3FF, 8, 1'b0, 96'h0000_0000_8877_6655_4433_2211, 2, 4'hF, 1'b1,
               10'h000, 32'h0, 32'h8877_6655};
    tbl[4] = '{10'h030, 7, 1'b0, 96'h0000_0000_0007_0605_0403_0201, 2, 4'b0111, 1'b0,
               10'h031, 32'hFFFF_FFFF, 32'hFF07_0605};
    tbl[5] = '{10'h060, 1, 1'b0, 96'h0000_0000_0000_0000_0000_005A, 1, 4'b0001, 1'b0,
               10'h060, 32'hAAAA_AAAA, 32'hAAAA_AA5A};
    tbl[6] = '{10'h050, 0, 1'b0, 96'h0, 0, 4'b0000, 1'b0,
               10'h050, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    reset = 1'b0; start = 1'b1; base_addr = '0; byte_len = 16'd4;
    in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_wea", {60'd0, wea}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_adra_dina", {22'd0, adra, dina}, 64'd0);
    check("rst_wrap", {63'd0, wrap_err}, 64'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_wea", {60'd0, wea}, 64'd0);
    in_valid = 1'b0;

    for (int i = 0; i < 7; i++) run_load(tbl[i]);

    // Reset after 2 of 4 bytes: partial word must be dropped.
    wr0 = wr_cnt;
    base_addr = 10'h040; byte_len = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    in_data = 8'hAA;
    @(posedge clk); #1;
    in_data = 8'hBB;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_wea", {60'd0, wea}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_write", 64'(wr_cnt - wr0), 64'd0);
    check("midrst_idle", {63'd0, busy}, 64'd0);
    check("midrst_mem", {32'd0, mem[10'h040]}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
